// File: rtl/uart_dbg_pkg.sv
// Shared types and constants for the UART debug bridge.
package uart_dbg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RX_ADDR,
        RX_DATA,
        ISSUE,
        WAIT_RDY,
        TX_RESP
    } state_e;

    localparam logic [7:0]  DBG_CMD_NOP = 8'h00;
    localparam int unsigned FRAME_BYTES = 9;

endpackage

// File: rtl/uart_dbg_bridge_uart_phy.sv
// 8N1 UART receiver and transmitter sharing one bit-period setting.
module uart_phy
    import uart_dbg_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rstn_i,
    input  logic       rx_i,
    output logic       tx_o,
    output logic [7:0] rx_byte_o,
    output logic       rx_valid_o,
    input  logic [7:0] tx_byte_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o
);

    localparam logic [15:0] BIT_M1  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]  rx_sync_q;
    logic        rx_prev_q;
    logic        rx_busy_q;
    logic        rx_wait_hi_q;
    logic        rx_valid_q;
    logic [15:0] rx_cnt_q;
    logic [3:0]  rx_bitn_q;
    logic [7:0]  rx_shift_q;
    logic        rx_s;

    assign rx_s       = rx_sync_q[1];
    assign rx_byte_o  = rx_shift_q;
    assign rx_valid_o = rx_valid_q;

    // Bit index 0 is the start bit, 1..8 data, 9 the stop bit.
    always_ff @(posedge clk) begin
        if (!rstn_i) begin
            rx_sync_q    <= 2'b11;
            rx_prev_q    <= 1'b1;
            rx_busy_q    <= 1'b0;
            rx_wait_hi_q <= 1'b0;
            rx_valid_q   <= 1'b0;
            rx_cnt_q     <= '0;
            rx_bitn_q    <= '0;
            rx_shift_q   <= '0;
        end else begin
            rx_sync_q  <= {rx_sync_q[0], rx_i};
            rx_prev_q  <= rx_s;
            rx_valid_q <= 1'b0;
            if (rx_wait_hi_q) begin
                if (rx_s) rx_wait_hi_q <= 1'b0;
            end else if (!rx_busy_q) begin
                if (rx_prev_q && !rx_s) begin
                    rx_busy_q <= 1'b1;
                    rx_cnt_q  <= HALF_M1;
                    rx_bitn_q <= '0;
                end
            end else if (rx_cnt_q != '0) begin
                rx_cnt_q <= rx_cnt_q - 16'd1;
            end else begin
                rx_cnt_q  <= BIT_M1;
                rx_bitn_q <= rx_bitn_q + 4'd1;
                if (rx_bitn_q == 4'd0) begin
                    if (rx_s) rx_busy_q <= 1'b0;
                end else if (rx_bitn_q == 4'd9) begin
                    rx_busy_q <= 1'b0;
                    if (rx_s) rx_valid_q   <= 1'b1;
                    else      rx_wait_hi_q <= 1'b1;
                end else begin
                    rx_shift_q <= {rx_s, rx_shift_q[7:1]};
                end
            end
        end
    end

    logic        tx_busy_q;
    logic [15:0] tx_cnt_q;
    logic [3:0]  tx_bitn_q;
    logic [9:0]  tx_shift_q;
    logic        tx_last;

    // Accepting during the final stop-bit cycle lets bytes run back to back.
    assign tx_last    = tx_busy_q && (tx_cnt_q == '0) && (tx_bitn_q == 4'd9);
    assign tx_ready_o = !tx_busy_q || tx_last;
    assign tx_o       = tx_busy_q ? tx_shift_q[0] : 1'b1;

    always_ff @(posedge clk) begin
        if (!rstn_i) begin
            tx_busy_q  <= 1'b0;
            tx_cnt_q   <= '0;
            tx_bitn_q  <= '0;
            tx_shift_q <= '1;
        end else if (tx_valid_i && tx_ready_o) begin
            tx_busy_q  <= 1'b1;
            tx_cnt_q   <= BIT_M1;
            tx_bitn_q  <= '0;
            tx_shift_q <= {1'b1, tx_byte_i, 1'b0};
        end else if (tx_last) begin
            tx_busy_q <= 1'b0;
        end else if (tx_busy_q) begin
            if (tx_cnt_q != '0) begin
                tx_cnt_q <= tx_cnt_q - 16'd1;
            end else begin
                tx_cnt_q   <= BIT_M1;
                tx_bitn_q  <= tx_bitn_q + 4'd1;
                tx_shift_q <= {1'b1, tx_shift_q[9:1]};
            end
        end
    end

endmodule

// File: rtl/uart_dbg_bridge.sv
// UART-to-debug bridge: 9-byte request frame in, 4-byte read data out.
// Optional inter-byte timeout enabled by defining UART_DBG_TIMEOUT_EN.
module uart_dbg_bridge
    import uart_dbg_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT   = 868,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rstn_i,
    input  logic        uart_rx_i,
    output logic        uart_tx_o,
    output logic [7:0]  dbg_cmd_o,
    output logic [31:0] dbg_addr_o,
    output logic [31:0] dbg_data_o,
    input  logic [31:0] dbg_data_i,
    input  logic        dbg_ready_i,
    output logic        busy_o
);

    logic [7:0] rx_byte, tx_byte;
    logic       rx_valid, tx_valid, tx_ready;

    uart_phy #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_phy (
        .clk        (clk),
        .rstn_i     (rstn_i),
        .rx_i       (uart_rx_i),
        .tx_o       (uart_tx_o),
        .rx_byte_o  (rx_byte),
        .rx_valid_o (rx_valid),
        .tx_byte_i  (tx_byte),
        .tx_valid_i (tx_valid),
        .tx_ready_o (tx_ready)
    );

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        last_q, last_d;
    logic [7:0]  cmd_q, cmd_d, dbg_cmd_q, dbg_cmd_d;
    logic [31:0] addr_q, addr_d, data_q, data_d, resp_q, resp_d;
    logic [31:0] dbg_addr_q, dbg_addr_d, dbg_data_q, dbg_data_d;
    logic        timeout;

`ifdef UART_DBG_TIMEOUT_EN
    logic [31:0] idle_q, idle_d;
    logic        in_frame;

    always_comb begin
        in_frame = (state_q == RX_ADDR) || (state_q == RX_DATA);
        idle_d   = (in_frame && !rx_valid) ? idle_q + 32'd1 : 32'd0;
        timeout  = in_frame && !rx_valid && (idle_q == 32'(TIMEOUT_CYCLES - 1));
    end

    always_ff @(posedge clk) begin
        if (!rstn_i) idle_q <= '0;
        else         idle_q <= idle_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        data_d     = data_q;
        resp_d     = resp_q;
        dbg_cmd_d  = dbg_cmd_q;
        dbg_addr_d = dbg_addr_q;
        dbg_data_d = dbg_data_q;
        tx_valid   = 1'b0;
        tx_byte    = resp_q[31:24];
        unique case (state_q)
            IDLE: if (rx_valid && rx_byte != DBG_CMD_NOP) begin
                cmd_d   = rx_byte;
                cnt_d   = '0;
                state_d = RX_ADDR;
            end
            RX_ADDR: if (rx_valid) begin
                addr_d = {addr_q[23:0], rx_byte};
                cnt_d  = cnt_q + 2'd1;
                if (cnt_q == 2'd3) state_d = RX_DATA;
            end
            RX_DATA: if (rx_valid) begin
                data_d = {data_q[23:0], rx_byte};
                cnt_d  = cnt_q + 2'd1;
                if (cnt_q == 2'd3) state_d = ISSUE;
            end
            ISSUE: begin
                dbg_cmd_d  = cmd_q;
                dbg_addr_d = addr_q;
                dbg_data_d = data_q;
                state_d    = WAIT_RDY;
            end
            WAIT_RDY: if (dbg_ready_i) begin
                resp_d    = dbg_data_i;
                dbg_cmd_d = DBG_CMD_NOP;
                cnt_d     = '0;
                last_d    = 1'b0;
                state_d   = TX_RESP;
            end
            TX_RESP: begin
                // Stay until the last stop bit has gone out, then release.
                tx_valid = !last_q;
                if (tx_valid && tx_ready) begin
                    resp_d = {resp_q[23:0], 8'h00};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) last_d = 1'b1;
                end else if (last_q && tx_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (timeout) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_q     <= 1'b0;
            cmd_q      <= DBG_CMD_NOP;
            addr_q     <= '0;
            data_q     <= '0;
            resp_q     <= '0;
            dbg_cmd_q  <= DBG_CMD_NOP;
            dbg_addr_q <= '0;
            dbg_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            resp_q     <= resp_d;
            dbg_cmd_q  <= dbg_cmd_d;
            dbg_addr_q <= dbg_addr_d;
            dbg_data_q <= dbg_data_d;
        end
    end

    assign dbg_cmd_o  = dbg_cmd_q;
    assign dbg_addr_o = dbg_addr_q;
    assign dbg_data_o = dbg_data_q;
    assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_dbg_bridge.sv
// Directed plus randomized bench for uart_dbg_bridge with a frame-level reference model.
module tb_uart_dbg_bridge;

    localparam int CPB = 8;
    localparam int TO  = 400;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        rx = 1'b1;
    logic        tx;
    logic [7:0]  cmd;
    logic [31:0] addr, wdat;
    logic [31:0] rdata_drv = '0;
    logic        rdy = 1'b0;
    logic        busy;

    uart_dbg_bridge #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rstn_i      (rstn),
        .uart_rx_i   (rx),
        .uart_tx_o   (tx),
        .dbg_cmd_o   (cmd),
        .dbg_addr_o  (addr),
        .dbg_data_o  (wdat),
        .dbg_data_i  (rdata_drv),
        .dbg_ready_i (rdy),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int errors = 0;
    int checks = 0;

    // Count commands issued: a 0 -> non-zero change of dbg_cmd_o.
    int         issues = 0;
    logic [7:0] cmd_prev = 8'h00;
    always @(posedge clk) begin
        if (cmd != 8'h00 && cmd_prev == 8'h00) issues++;
        cmd_prev = cmd;
    end

    // Serial line observer: decodes each transmitted character at bit midpoints.
    logic [7:0] tx_q[$];
    int         tx_t[$];
    bit         tx_ok[$];
    int         tx_edges = 0;
    logic [7:0] mon_b;
    int         mon_t;
    bit         mon_ok;

    always @(tx) tx_edges++;

    always begin
        @(negedge tx);
        mon_t  = cyc;
        mon_ok = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        if (tx !== 1'b0) mon_ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            mon_b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        if (tx !== 1'b1) mon_ok = 1'b0;
        tx_q.push_back(mon_b);
        tx_t.push_back(mon_t);
        tx_ok.push_back(mon_ok);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = bad_stop ? 1'b0 : 1'b1;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    // Frame layout: cmd, address MSB byte first, data MSB byte first.
    task automatic send_frame(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d,
                              input bit early_rdy);
        logic [7:0] fb[9];
        fb[0] = c;
        for (int k = 0; k < 4; k++) begin
            fb[1 + k] = a[31 - 8 * k -: 8];
            fb[5 + k] = d[31 - 8 * k -: 8];
        end
        rdy = early_rdy;
        for (int k = 0; k < 9; k++) begin
            if (k == 8) rdy = 1'b0;
            send_byte(fb[k], 1'b0);
        end
    endtask

    task automatic run_txn(input string tag, input logic [7:0] c, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] rd, input int delay,
                           input bit early_rdy);
        int base;
        bit seen;
        bit held;
        bit done;
        base = issues;
        seen = 1'b0;
        send_frame(c, a, d, early_rdy);
        for (int i = 0; i < 200 && !seen; i++) begin
            if (cmd !== 8'h00) seen = 1'b1;
            else @(negedge clk);
        end
        chk({tag, "_cmd_seen"}, 32'(seen), 32'd1);
        chk({tag, "_cmd"}, 32'(cmd), 32'(c));
        chk({tag, "_addr"}, addr, a);
        chk({tag, "_wdata"}, wdat, d);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        tx_q.delete();
        tx_t.delete();
        tx_ok.delete();
        held = 1'b1;
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            if (cmd !== c) held = 1'b0;
        end
        chk({tag, "_cmd_held"}, 32'(held), 32'd1);
        rdata_drv = rd;
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
        rdata_drv = $urandom;
        chk({tag, "_cmd_clear"}, 32'(cmd), 32'h0);
        chk({tag, "_issue_cnt"}, 32'(issues - base), 32'd1);
        done = 1'b0;
        for (int i = 0; i < 1000 && !done; i++) begin
            @(negedge clk);
            if (busy === 1'b0) done = 1'b1;
        end
        chk({tag, "_busy_done"}, 32'(done), 32'd1);
        chk({tag, "_tx_count"}, 32'(tx_q.size()), 32'd4);
        for (int k = 0; k < 4 && k < tx_q.size(); k++) begin
            chk({tag, "_tx_byte"}, 32'(tx_q[k]), 32'(rd[31 - 8 * k -: 8]));
            chk({tag, "_tx_frame"}, 32'(tx_ok[k]), 32'd1);
            if (k > 0) chk({tag, "_tx_spacing"}, 32'(tx_t[k] - tx_t[k - 1]), 32'(10 * CPB));
        end
        chk({tag, "_addr_idle"}, addr, a);
        chk({tag, "_wdata_idle"}, wdat, d);
        chk({tag, "_tx_idle"}, 32'(tx), 32'd1);
    endtask

    initial begin
        int e0, i0;
        bit seen;
        logic [7:0]  rc;
        logic [31:0] ra, rw, rr;

        rstn = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_cmd", 32'(cmd), 32'h0);
        chk("rst_addr", addr, 32'h0);
        chk("rst_wdata", wdat, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        rstn = 1'b1;
        repeat (4) @(negedge clk);

        run_txn("write", 8'h01, 32'h0000_4000, 32'hDEAD_BEEF, $urandom, 5, 1'b0);
        run_txn("read", 8'h02, 32'h0000_8100, 32'h0000_0000, 32'h1234_5678, 5, 1'b0);

        send_byte(8'h55, 1'b1);
        repeat (2 * CPB) @(negedge clk);
        chk("framing_busy", 32'(busy), 32'd0);
        chk("framing_cmd", 32'(cmd), 32'h0);
        run_txn("after_framing", 8'h03, $urandom, $urandom, $urandom, 2, 1'b0);

        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        chk("zeros_busy", 32'(busy), 32'd0);
        run_txn("after_zeros", 8'h04, $urandom, $urandom, $urandom, 1, 1'b0);

        for (int n = 0; n < 4; n++) begin
            rc = 8'($urandom_range(1, 255));
            ra = $urandom;
            rw = $urandom;
            rr = $urandom;
            run_txn("random", rc, ra, rw, rr, int'($urandom_range(0, 7)), n == 0);
        end

        i0 = issues;
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        repeat (500) @(negedge clk);
`ifdef UART_DBG_TIMEOUT_EN
        chk("timeout_busy", 32'(busy), 32'd0);
`else
        chk("stall_busy", 32'(busy), 32'd1);
`endif
        chk("stall_cmd", 32'(cmd), 32'h0);
        chk("stall_issue", 32'(issues - i0), 32'd0);

        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst2_busy", 32'(busy), 32'd0);
        send_frame(8'h02, $urandom, $urandom, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (cmd !== 8'h00) seen = 1'b1;
            else @(negedge clk);
        end
        chk("abort_cmd_seen", 32'(seen), 32'd1);
        tx_q.delete();
        tx_t.delete();
        tx_ok.delete();
        rdata_drv = 32'h0F0F_0F0F;
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (tx_t.size() >= 2) seen = 1'b1;
        end
        chk("abort_byte2_started", 32'(seen), 32'd1);
        repeat (20) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        chk("abort_tx", 32'(tx), 32'd1);
        chk("abort_cmd", 32'(cmd), 32'h0);
        chk("abort_busy", 32'(busy), 32'd0);
        rstn = 1'b1;
        e0 = tx_edges;
        i0 = issues;
        repeat (300) @(negedge clk);
        chk("abort_no_tx_edges", 32'(tx_edges - e0), 32'd0);
        chk("abort_no_issue", 32'(issues - i0), 32'd0);
        chk("abort_busy_after", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_dbg_bridge.md
UART_DBG_BRIDGE -- requirements
Module: uart_dbg_bridge

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868; clk cycles per UART bit (100 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000; inter-byte timeout in clk cycles.
REQ-003 SHALL have port clk, input, 1, single system clock.
REQ-004 SHALL have port rstn_i, input, 1, reset that is synchronous and active-low.
REQ-005 SHALL have port uart_rx_i, input, 1, asynchronous UART receive line (8N1, idle high).
REQ-006 SHALL have port uart_tx_o, output, 1, UART transmit line (8N1, idle high).
REQ-007 SHALL have port dbg_cmd_o, output, 8, debug command to the debug module; 0x00 means no command.
REQ-008 SHALL have port dbg_addr_o, output, 32, debug address.
REQ-009 SHALL have port dbg_data_o, output, 32, debug write data.
REQ-010 SHALL have port dbg_data_i, input, 32, debug read data.
REQ-011 SHALL have port dbg_ready_i, input, 1, debug module has completed the command.
REQ-012 SHALL have port busy_o, output, 1, asserted whenever the frame FSM is not in IDLE.

Function
REQ-013 RX SHALL pass uart_rx_i through a 2-FF synchronizer, detect the start bit on a falling edge, and sample each bit at its midpoint (CLKS_PER_BIT/2 after the edge, then every CLKS_PER_BIT); bits arrive LSB first.
REQ-014 RX SHALL discard any byte whose stop bit samples 0 (framing error) and SHALL re-arm only after the line returns high.
REQ-015 TX SHALL send a start bit, 8 data bits LSB first, and one stop bit, each exactly CLKS_PER_BIT cycles long, and SHALL hold uart_tx_o at 1 when idle.
REQ-016 The request frame SHALL be 9 bytes: cmd, then addr[31:24..7:0], then data[31:24..7:0], each field MSB byte first.
REQ-017 The frame FSM SHALL have states IDLE, RX_ADDR, RX_DATA, ISSUE, WAIT_RDY, and TX_RESP.
REQ-018 In IDLE, a non-zero byte SHALL be latched as the cmd and move the FSM to RX_ADDR; a 0x00 byte SHALL be ignored.
REQ-019 RX_ADDR and RX_DATA SHALL each shift in 4 bytes via a 2-bit byte counter, then advance; RX_DATA SHALL advance to ISSUE.
REQ-020 ISSUE SHALL drive dbg_cmd_o, dbg_addr_o, and dbg_data_o on the next cycle and move to WAIT_RDY.
REQ-021 In WAIT_RDY, dbg_cmd_o SHALL hold the cmd until dbg_ready_i=1 is sampled; in that same cycle dbg_data_i SHALL be captured, and dbg_cmd_o SHALL be 0x00 from the following cycle.
REQ-022 TX_RESP SHALL transmit the 4 captured bytes MSB first, back to back, then return to IDLE.
REQ-023 Bytes received in ISSUE, WAIT_RDY, or TX_RESP SHALL be dropped.
REQ-024 dbg_ready_i asserted outside WAIT_RDY SHALL be ignored.
REQ-025 dbg_addr_o and dbg_data_o SHALL hold their last values while idle.
REQ-026 busy_o SHALL be 0 in IDLE and 1 in every other state.

Reset
REQ-027 With rstn_i=0 at a clk edge, all state SHALL reset: FSM=IDLE, counters=0, uart_tx_o=1, dbg_cmd_o=0x00, dbg_addr_o=0, dbg_data_o=0, busy_o=0.
REQ-028 A reset mid-frame or mid-transmission SHALL abort it; no partial byte SHALL be sent after reset and no debug command SHALL be issued.

Configuration
REQ-029 With UART_DBG_TIMEOUT_EN defined, an idle counter SHALL run in RX_ADDR and RX_DATA and be cleared by each received byte; on reaching TIMEOUT_CYCLES the FSM SHALL return to IDLE and the partial frame SHALL be discarded.
REQ-030 Without UART_DBG_TIMEOUT_EN, no timeout logic SHALL exist and the FSM SHALL wait indefinitely for the remaining bytes.

Structure
REQ-031 A shared package uart_dbg_pkg SHALL hold the FSM state enum, DBG_CMD_NOP=8'h00, and FRAME_BYTES=9.
REQ-032 The serial RX/TX logic SHALL be one sub-module uart_phy, parameterized by CLKS_PER_BIT, that exposes rx_byte/rx_valid and tx_byte/tx_valid/tx_ready; the frame FSM SHALL live in uart_dbg_bridge.

Verification (CLKS_PER_BIT=8, TIMEOUT_CYCLES=400)
REQ-033 Send frame 01 00 00 40 00 DE AD BE EF; ready after 5 cycles -> dbg_cmd_o=0x01, dbg_addr_o=0x00004000, dbg_data_o=0xDEADBEEF held until ready, then 0x00.
REQ-034 Send read frame 02 00 00 81 00 00 00 00 00 with dbg_data_i=0x12345678 at ready -> TX bytes 12 34 56 78, each 80 cycles long, then busy_o=0.
REQ-035 Send byte 0x55 with stop bit forced 0, then a valid frame -> first byte discarded, FSM stays IDLE, and the frame executes normally.
REQ-036 Send 00 00 and then a valid frame -> the leading zeros are ignored and exactly one command is issued.
REQ-037 With UART_DBG_TIMEOUT_EN, send 01 00 and stall for 500 cycles -> FSM returns to IDLE, busy_o=0, and no dbg_cmd_o is issued; without the macro, busy_o stays 1.
REQ-038 Assert rstn_i=0 during TX_RESP byte 2 -> next cycle uart_tx_o=1, dbg_cmd_o=0x00, busy_o=0, and no further TX edges occur.
